vga_ctrl: RTL and testbench
===========================

# vga_ctrl

Fixed-mode VGA timing generator for 640x480 at 60 Hz, driven by a 25 MHz pixel clock. It produces horizontal and vertical sync, a blanking flag and the DAC clock. It tells the pixel source which visible pixel is current and passes the source's 10-bit RGB to the DAC, forcing black outside the visible window. It sits between the game renderer, which computes colour from X/Y, and the board's VGA DAC pins.

## Interface
- H_SYNC, 96: HS pulse width in pixel clocks
- H_BACK, 48: horizontal back porch
- H_ACT, 640: visible pixels per line
- H_FRONT, 16: horizontal front porch
- V_SYNC, 2: VS pulse width in lines
- V_BACK, 33: vertical back porch
- V_ACT, 480: visible lines
- V_FRONT, 10: vertical front porch

Ports (one clock; reset is asynchronous and active-high):
- iCLK  in  1  pixel clock, 25 MHz
- iRST  in  1  asynchronous, active-high reset
- iRed / iGreen / iBlue  in  10 each  pixel colour from the renderer
- oCurrent_X  out  11  visible column 0..639; 0 outside the visible window
- oCurrent_Y  out  11  visible row 0..479; 0 outside the visible window
- oRequest  out  1  high while the current pixel is visible
- oVGA_R / oVGA_G / oVGA_B  out  10 each  DAC colour
- oVGA_HS  out  1  horizontal sync, active-low
- oVGA_VS  out  1  vertical sync, active-low
- oVGA_BLANK  out  1  active-low blank: high during visible pixels
- oVGA_CLOCK  out  1  DAC clock, equal to ~iCLK

## Operation
- Line and frame sizes:
  - H_TOTAL = sum of the H_* parameters = 800.
  - V_TOTAL = sum of the V_* parameters = 525.
  - X_START = H_SYNC + H_BACK = 144.
  - Y_START = V_SYNC + V_BACK = 35.
- h_cnt (11-bit) counts 0..H_TOTAL-1 every clock and wraps to 0.
- v_cnt (11-bit) increments on each h_cnt wrap and wraps to 0 after V_TOTAL-1.
- Sync outputs:
  - oVGA_HS = 0 while h_cnt < H_SYNC, else 1.
  - oVGA_VS = 0 while v_cnt < V_SYNC, else 1.
- Visible window:
  - h_act = X_START ≤ h_cnt < X_START+H_ACT.
  - v_act = Y_START ≤ v_cnt < Y_START+V_ACT.
  - oRequest = oVGA_BLANK = h_act & v_act.
- Coordinates:
  - oCurrent_X = h_cnt − X_START when h_act, else 0.
  - oCurrent_Y = v_cnt − Y_START when v_act, else 0.
- Colour: oVGA_R/G/B = iRed/iGreen/iBlue when oRequest is high, else 0.
- Reset values:
  - h_cnt = v_cnt = 0.
  - oVGA_HS = oVGA_VS = 0, since both counters are inside the sync pulse.
  - oRequest = oVGA_BLANK = 0.
  - X = Y = 0; RGB = 0.
- The mode is fixed by parameters; there are no run-time registers.

## Timing
- The only state is h_cnt and v_cnt, both updated on posedge iCLK.
- All outputs except oVGA_CLOCK are combinational decodes of the counters and the colour inputs:
  - zero latency from the counters to sync, X/Y and request;
  - zero latency from iRGB to oVGA_RGB.
- A renderer that registers its colour one cycle after sampling X/Y produces a 1-pixel right shift. That offset is accepted and is not compensated here.
- Line period is 800 clocks; HS is low for clocks 0..95 of each line.
- Frame period is 525 × 800 = 420 000 clocks; VS is low for the first 1600 clocks of each frame.
- The first visible pixel of a frame is at h_cnt=144, v_cnt=35. The last is at h_cnt=783, v_cnt=514.
- Wrap boundary:
  - At h_cnt=799 the next clock gives h_cnt=0 and v_cnt+1.
  - At h_cnt=799, v_cnt=524 the next clock gives both counters = 0.
- Reset mid-frame forces all outputs to their reset values immediately, without waiting for a clock edge. Counting resumes from 0 on the first clock edge after iRST deasserts.

## Structure
- Package vga_timing_pkg holds the default 640x480 constants and the derived X_START, Y_START, H_TOTAL and V_TOTAL.
- One sub-module, vga_axis_timer, is instantiated twice:
  - horizontal instance: always enabled, counting pixels;
  - vertical instance: enabled on the horizontal wrap, counting lines.
- Each instance has parameters SYNC/BACK/ACT/FRONT and outputs cnt, sync_n, active, coord and wrap.

## Test plan
- Reset: assert iRST mid-line -> immediately HS=0, VS=0, BLANK=0, X=Y=0, RGB=0. After release, the first edge gives h_cnt=1.
- Horizontal timing: measure HS -> low for exactly 96 clocks, with a period of 800 clocks. Request is high for exactly 640 consecutive clocks per visible line, starting 144 clocks after HS falls.
- Vertical timing: measure VS -> low for exactly 1600 clocks, with a period of 420 000 clocks. There are exactly 480 lines with request high per frame.
- Coordinates: on the first visible pixel -> X=0, Y=0. On the last -> X=639, Y=479. Outside the window -> X=Y=0.
- Colour gating: drive iRed=10'h3FF, iGreen=10'h155, iBlue=0 constantly -> the same values on the outputs while request=1, and 0 on all three during blanking.
- oVGA_CLOCK: check it is the inverse of iCLK at every sample, including while iRST is asserted.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and shared types for the VGA timing generator.
package vga_timing_pkg;

    localparam int H_SYNC  = 96;
    localparam int H_BACK  = 48;
    localparam int H_ACT   = 640;
    localparam int H_FRONT = 16;
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 33;
    localparam int V_ACT   = 480;
    localparam int V_FRONT = 10;

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;
    localparam int X_START = H_SYNC + H_BACK;
    localparam int Y_START = V_SYNC + V_BACK;

    typedef logic [10:0] coord_t;
    typedef logic [9:0]  colour_t;

    typedef struct packed {
        colour_t r;
        colour_t g;
        colour_t b;
    } rgb_t;

endpackage

// File: rtl/vga_ctrl_if.sv
// Renderer/DAC side of the VGA timing generator: colour in, coordinates, syncs and DAC colour out.
interface vga_ctrl_if;
    import vga_timing_pkg::*;

    colour_t iRed;
    colour_t iGreen;
    colour_t iBlue;
    coord_t  oCurrent_X;
    coord_t  oCurrent_Y;
    logic    oRequest;
    colour_t oVGA_R;
    colour_t oVGA_G;
    colour_t oVGA_B;
    logic    oVGA_HS;
    logic    oVGA_VS;
    logic    oVGA_BLANK;
    logic    oVGA_CLOCK;

    modport master (
        output iRed, iGreen, iBlue,
        input  oCurrent_X, oCurrent_Y, oRequest,
        input  oVGA_R, oVGA_G, oVGA_B,
        input  oVGA_HS, oVGA_VS, oVGA_BLANK, oVGA_CLOCK
    );

    modport slave (
        input  iRed, iGreen, iBlue,
        output oCurrent_X, oCurrent_Y, oRequest,
        output oVGA_R, oVGA_G, oVGA_B,
        output oVGA_HS, oVGA_VS, oVGA_BLANK, oVGA_CLOCK
    );

endinterface

// File: rtl/vga_axis_timer.sv
// One timing axis (pixels within a line, or lines within a frame): counter plus sync/active decode.
module vga_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int SYNC  = 96,
    parameter int BACK  = 48,
    parameter int ACT   = 640,
    parameter int FRONT = 16
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t cnt,
    output logic   sync_n,
    output logic   active,
    output coord_t coord,
    output logic   wrap
);

    localparam int     TOTAL = SYNC + BACK + ACT + FRONT;
    localparam coord_t LAST  = coord_t'(TOTAL - 1);
    localparam coord_t START = coord_t'(SYNC + BACK);
    localparam coord_t STOP  = coord_t'(SYNC + BACK + ACT);

    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 11'd1;
        end
    end

    // Everything below is a pure decode of cnt, so reset reaches the outputs without a clock.
    assign sync_n = (cnt >= coord_t'(SYNC));
    assign active = (cnt >= START) && (cnt < STOP);
    assign coord  = active ? (cnt - START) : '0;

endmodule

// File: rtl/vga_ctrl.sv
// Fixed-mode VGA timing generator: two axis timers, window decode and colour gating to the DAC.
module vga_ctrl #(
    parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
    parameter int H_BACK  = vga_timing_pkg::H_BACK,
    parameter int H_ACT   = vga_timing_pkg::H_ACT,
    parameter int H_FRONT = vga_timing_pkg::H_FRONT,
    parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
    parameter int V_BACK  = vga_timing_pkg::V_BACK,
    parameter int V_ACT   = vga_timing_pkg::V_ACT,
    parameter int V_FRONT = vga_timing_pkg::V_FRONT
) (
    input  logic        iCLK,
    input  logic        iRST,
    vga_ctrl_if.slave   vga
);
    import vga_timing_pkg::*;

    coord_t h_cnt;
    coord_t v_cnt;
    coord_t h_coord;
    coord_t v_coord;
    logic   h_sync_n;
    logic   v_sync_n;
    logic   h_act;
    logic   v_act;
    logic   h_wrap;
    logic   v_wrap;
    logic   visible;
    rgb_t   pix;
    logic   unused_axis;

    vga_axis_timer #(
        .SYNC  (H_SYNC),
        .BACK  (H_BACK),
        .ACT   (H_ACT),
        .FRONT (H_FRONT)
    ) u_h_timer (
        .clk    (iCLK),
        .rst    (iRST),
        .en     (1'b1),
        .cnt    (h_cnt),
        .sync_n (h_sync_n),
        .active (h_act),
        .coord  (h_coord),
        .wrap   (h_wrap)
    );

    vga_axis_timer #(
        .SYNC  (V_SYNC),
        .BACK  (V_BACK),
        .ACT   (V_ACT),
        .FRONT (V_FRONT)
    ) u_v_timer (
        .clk    (iCLK),
        .rst    (iRST),
        .en     (h_wrap),
        .cnt    (v_cnt),
        .sync_n (v_sync_n),
        .active (v_act),
        .coord  (v_coord),
        .wrap   (v_wrap)
    );

    // Raw counters and frame wrap are kept on the timer ports for debug taps only.
    assign unused_axis = ^{h_cnt, v_cnt, v_wrap};

    assign visible = h_act & v_act;
    assign pix     = visible ? rgb_t'{r: vga.iRed, g: vga.iGreen, b: vga.iBlue} : '0;

    assign vga.oCurrent_X = h_coord;
    assign vga.oCurrent_Y = v_coord;
    assign vga.oRequest   = visible;
    assign vga.oVGA_BLANK = visible;
    assign vga.oVGA_HS    = h_sync_n;
    assign vga.oVGA_VS    = v_sync_n;
    assign vga.oVGA_R     = pix.r;
    assign vga.oVGA_G     = pix.g;
    assign vga.oVGA_B     = pix.b;
    assign vga.oVGA_CLOCK = ~iCLK;

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: a default-mode instance and a tiny-mode instance checked against a closed-form timing model.
module tb_vga_ctrl;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        req;
        logic        blank;
        logic        hs;
        logic        vs;
        logic [9:0]  r;
        logic [9:0]  g;
        logic [9:0]  b;
    } obs_t;

    // Per instance: H sync, back, active, front, V sync, back, active, front.
    localparam int P [2][8] = '{'{96, 48, 640, 16, 2, 33, 480, 10},
                                '{4, 3, 8, 2, 2, 3, 5, 2}};

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   na;
    int   nb;
    int   checks   = 0;
    int   failures = 0;

    int   hs_low [2];
    int   hs_fall [2];
    int   vs_low [2];
    int   vs_fall [2];
    int   req_run [2];
    int   req_rises [2];
    bit   prev_hs [2];
    bit   prev_vs [2];
    bit   prev_req [2];

    always #20 clk = ~clk;

    vga_ctrl_if va ();
    vga_ctrl_if vb ();

    vga_ctrl dut_a (
        .iCLK (clk),
        .iRST (rst_a),
        .vga  (va)
    );

    vga_ctrl #(
        .H_SYNC (4), .H_BACK (3), .H_ACT (8), .H_FRONT (2),
        .V_SYNC (2), .V_BACK (3), .V_ACT (5), .V_FRONT (2)
    ) dut_b (
        .iCLK (clk),
        .iRST (rst_b),
        .vga  (vb)
    );

    // Clock edges seen since reset released; equals the frame position in pixels.
    always @(posedge clk or posedge rst_a) begin
        if (rst_a) na <= 0;
        else       na <= na + 1;
    end

    always @(posedge clk or posedge rst_b) begin
        if (rst_b) nb <= 0;
        else       nb <= nb + 1;
    end

    task automatic check(input string name, input int d, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%0d expected=%0d t=%0t", name, d, got, exp, $time);
        end
    endtask

    function automatic obs_t model(input int d, input int n, input bit in_rst,
                                   input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        obs_t e = '0;
        int ht, vt, h, v, xs, ys;
        bit hv, vv;
        if (in_rst) return e;
        ht = P[d][0] + P[d][1] + P[d][2] + P[d][3];
        vt = P[d][4] + P[d][5] + P[d][6] + P[d][7];
        h  = n % ht;
        v  = (n / ht) % vt;
        xs = P[d][0] + P[d][1];
        ys = P[d][4] + P[d][5];
        hv = (h >= xs) && (h < xs + P[d][2]);
        vv = (v >= ys) && (v < ys + P[d][6]);
        e.hs    = (h >= P[d][0]);
        e.vs    = (v >= P[d][4]);
        e.req   = hv && vv;
        e.blank = e.req;
        e.x     = hv ? 11'(h - xs) : 11'd0;
        e.y     = vv ? 11'(v - ys) : 11'd0;
        if (e.req) begin
            e.r = r;
            e.g = g;
            e.b = b;
        end
        return e;
    endfunction

    task automatic cmp_obs(input int d, input int n, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL outputs dut%0d n=%0d got x=%0d y=%0d req=%b blank=%b hs=%b vs=%b rgb=%h/%h/%h expected x=%0d y=%0d req=%b blank=%b hs=%b vs=%b rgb=%h/%h/%h",
                     d, n, got.x, got.y, got.req, got.blank, got.hs, got.vs, got.r, got.g, got.b,
                     exp.x, exp.y, exp.req, exp.blank, exp.hs, exp.vs, exp.r, exp.g, exp.b);
        end
    endtask

    // Interval measurements straight from the sampled waveforms.
    task automatic measure(input int d, input int n, input bit in_rst, input obs_t o);
        int ht;
        ht = P[d][0] + P[d][1] + P[d][2] + P[d][3];
        if (in_rst) begin
            hs_low[d] = 0;  hs_fall[d] = 0;
            vs_low[d] = 0;  vs_fall[d] = 0;
            req_run[d] = 0; req_rises[d] = 0;
            prev_hs[d] = 1'b0; prev_vs[d] = 1'b0; prev_req[d] = 1'b0;
            return;
        end
        if (!o.hs) hs_low[d]++;
        if (o.hs && !prev_hs[d]) begin
            check("hs_low_width", d, hs_low[d], P[d][0]);
            hs_low[d] = 0;
        end
        if (!o.hs && prev_hs[d]) begin
            check("hs_period", d, n - hs_fall[d], ht);
            hs_fall[d] = n;
        end
        if (!o.vs) vs_low[d]++;
        if (o.vs && !prev_vs[d]) begin
            check("vs_low_width", d, vs_low[d], P[d][4] * ht);
            vs_low[d] = 0;
        end
        if (!o.vs && prev_vs[d]) begin
            check("vs_period", d, n - vs_fall[d], ht * (P[d][4] + P[d][5] + P[d][6] + P[d][7]));
            check("visible_lines", d, req_rises[d], P[d][6]);
            vs_fall[d]   = n;
            req_rises[d] = 0;
        end
        if (o.req) req_run[d]++;
        if (o.req && !prev_req[d]) begin
            req_rises[d]++;
            check("req_offset", d, n - hs_fall[d], P[d][0] + P[d][1]);
        end
        if (!o.req && prev_req[d]) begin
            check("req_run", d, req_run[d], P[d][2]);
            req_run[d] = 0;
        end
        prev_hs[d]  = o.hs;
        prev_vs[d]  = o.vs;
        prev_req[d] = o.req;
    endtask

    always @(negedge clk) begin
        obs_t oa, ob, ea, eb;
        oa = '{x: va.oCurrent_X, y: va.oCurrent_Y, req: va.oRequest, blank: va.oVGA_BLANK,
               hs: va.oVGA_HS, vs: va.oVGA_VS, r: va.oVGA_R, g: va.oVGA_G, b: va.oVGA_B};
        ob = '{x: vb.oCurrent_X, y: vb.oCurrent_Y, req: vb.oRequest, blank: vb.oVGA_BLANK,
               hs: vb.oVGA_HS, vs: vb.oVGA_VS, r: vb.oVGA_R, g: vb.oVGA_G, b: vb.oVGA_B};
        ea = model(0, na, rst_a, va.iRed, va.iGreen, va.iBlue);
        eb = model(1, nb, rst_b, vb.iRed, vb.iGreen, vb.iBlue);
        cmp_obs(0, na, oa, ea);
        cmp_obs(1, nb, ob, eb);
        measure(0, na, rst_a, oa);
        measure(1, nb, rst_b, ob);
        check("dac_clock_low_phase", 0, va.oVGA_CLOCK, 1);
        check("dac_clock_low_phase", 1, vb.oVGA_CLOCK, 1);

        if (!rst_a) begin
            case (na)
                1:     begin check("first_edge_hs", 0, oa.hs, 0); check("first_edge_x", 0, oa.x, 0); end
                95:    check("hs_last_low", 0, oa.hs, 0);
                96:    check("hs_first_high", 0, oa.hs, 1);
                1599:  check("vs_last_low", 0, oa.vs, 0);
                1600:  check("vs_first_high", 0, oa.vs, 1);
                28143: check("pre_first_pixel_req", 0, oa.req, 0);
                28144: begin
                    check("first_pixel_req", 0, oa.req, 1);
                    check("first_pixel_x", 0, oa.x, 0);
                    check("first_pixel_y", 0, oa.y, 0);
                    check("first_pixel_r", 0, oa.r, 10'h3FF);
                    check("first_pixel_g", 0, oa.g, 10'h155);
                    check("first_pixel_b", 0, oa.b, 0);
                end
                28783: begin check("line_end_x", 0, oa.x, 639); check("line_end_req", 0, oa.req, 1); end
                28784: begin
                    check("front_porch_req", 0, oa.req, 0);
                    check("front_porch_x", 0, oa.x, 0);
                    check("front_porch_r", 0, oa.r, 0);
                    check("front_porch_g", 0, oa.g, 0);
                end
                default: ;
            endcase
        end
        if (!rst_b) begin
            case (nb)
                92:  begin check("b_first_req", 1, ob.req, 1); check("b_first_x", 1, ob.x, 0); check("b_first_y", 1, ob.y, 0); end
                167: begin check("b_last_req", 1, ob.req, 1); check("b_last_x", 1, ob.x, 7); check("b_last_y", 1, ob.y, 4); end
                168: check("b_after_last_req", 1, ob.req, 0);
                203: begin check("b_frame_end_hs", 1, ob.hs, 1); check("b_frame_end_vs", 1, ob.vs, 1); end
                204: begin check("b_wrap_hs", 1, ob.hs, 0); check("b_wrap_vs", 1, ob.vs, 0); check("b_wrap_y", 1, ob.y, 0); end
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        check("dac_clock_high_phase", 0, va.oVGA_CLOCK, 0);
        check("dac_clock_high_phase", 1, vb.oVGA_CLOCK, 0);
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            vb.iRed   = vb.iRed + 10'd37;
            vb.iGreen = vb.iGreen ^ 10'h2AA;
            vb.iBlue  = vb.iBlue + 10'd5;
        end
    end

    initial begin
        va.iRed   = 10'h3FF;
        va.iGreen = 10'h155;
        va.iBlue  = 10'h000;
        vb.iRed   = 10'h011;
        vb.iGreen = 10'h0F0;
        vb.iBlue  = 10'h203;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #5;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Land on line 36, pixel 300 of the default mode: visible, X=156, Y=1.
        repeat (29100) @(posedge clk);
        #4;
        check("pre_reset_req", 0, va.oRequest, 1);
        check("pre_reset_x", 0, va.oCurrent_X, 156);
        check("pre_reset_y", 0, va.oCurrent_Y, 1);
        check("pre_reset_hs", 0, va.oVGA_HS, 1);

        rst_a = 1'b1;
        #1;
        check("async_rst_hs", 0, va.oVGA_HS, 0);
        check("async_rst_vs", 0, va.oVGA_VS, 0);
        check("async_rst_blank", 0, va.oVGA_BLANK, 0);
        check("async_rst_req", 0, va.oRequest, 0);
        check("async_rst_x", 0, va.oCurrent_X, 0);
        check("async_rst_y", 0, va.oCurrent_Y, 0);
        check("async_rst_r", 0, va.oVGA_R, 0);
        check("async_rst_g", 0, va.oVGA_G, 0);
        check("async_rst_b", 0, va.oVGA_B, 0);

        repeat (3) @(posedge clk);
        #5;
        rst_a = 1'b0;
        repeat (1000) @(posedge clk);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
